// File: rtl/multichannel_localizer_if.sv
// Polar FFT beat stream into the multichannel localizer: {phase, magnitude} per mic, one mic per beat.
interface multichannel_localizer_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic [2*DATA_WIDTH-1:0] s_data_in;
  logic                    s_valid_in;
  logic                    s_last_in;
  logic                    s_ready_out;

  modport master (output s_data_in, output s_valid_in, output s_last_in, input s_ready_out);
  modport slave  (input s_data_in, input s_valid_in, input s_last_in, output s_ready_out);
endinterface

// File: rtl/multichannel_localizer.sv
// Ring-array direction finder: accumulates projected phase differences per frame and resolves the angle by CORDIC.
// Optional LOCALIZER_MAG_WEIGHT_EN scales each difference by the central-mic magnitude.
module multichannel_localizer #(
  parameter int NUM_MICS     = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int ACC_WIDTH    = 48,
  parameter int CORDIC_ITERS = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  multichannel_localizer_if.slave   s_bus,
  input  logic [DATA_WIDTH-1:0]     threshold_in,
  output logic [15:0]               angle_out,
  output logic                      angle_valid_out,
  output logic                      align_err_out,
  output logic [15:0]               frame_drop_count_out
);
  localparam int IDX_W = $clog2(NUM_MICS);
  localparam int CW    = 17;
  localparam int PW    = DATA_WIDTH + CW;
  localparam int IT_W  = 4;
  localparam real PI   = 3.14159265358979323846;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MICS - 1);
  localparam logic [IT_W-1:0]  LAST_IT  = IT_W'(CORDIC_ITERS - 1);

  typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;

  function automatic real series_sin(input real a);
    real term, sum;
    term = a;
    sum  = a;
    for (int n = 1; n < 12; n++) begin
      term = -term * a * a / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Unit vector of ring mic k in Q1.15; sin(x) = -sin(x - pi) keeps the series argument small.
  function automatic logic signed [CW-1:0] ring_coef(input int k, input bit use_sin);
    real ang, r;
    int  q;
    ang = 2.0 * PI * real'(k - 1) / real'(NUM_MICS - 1) + (use_sin ? 0.0 : PI / 2.0) - PI;
    r   = -series_sin(ang);
    q   = (k == 0) ? 0 : int'(r * 32768.0);
    return CW'(q);
  endfunction

  function automatic logic [15:0] atan_lut(input logic [IT_W-1:0] i);
    logic [15:0] v;
    case (i)
      4'd0:    v = 16'd8192;
      4'd1:    v = 16'd4836;
      4'd2:    v = 16'd2555;
      4'd3:    v = 16'd1297;
      4'd4:    v = 16'd651;
      4'd5:    v = 16'd326;
      4'd6:    v = 16'd163;
      4'd7:    v = 16'd81;
      4'd8:    v = 16'd41;
      4'd9:    v = 16'd20;
      4'd10:   v = 16'd10;
      4'd11:   v = 16'd5;
      4'd12:   v = 16'd3;
      4'd13:   v = 16'd1;
      4'd14:   v = 16'd1;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

  logic signed [CW-1:0] cos_s [NUM_MICS];
  logic signed [CW-1:0] sin_s [NUM_MICS];
  for (genvar k = 0; k < NUM_MICS; k++) begin : g_coef
    localparam logic signed [CW-1:0] COS_K = ring_coef(k, 1'b0);
    localparam logic signed [CW-1:0] SIN_K = ring_coef(k, 1'b1);
    assign cos_s[k] = COS_K;
    assign sin_s[k] = SIN_K;
  end

  logic                         ready_r, gate_r, align_err_r, angle_valid_r, zero_r;
  logic                         s1_valid_r, s1_last_r, s1_abort_r, s2_last_r;
  logic [IDX_W-1:0]             mic_idx_r;
  logic signed [DATA_WIDTH-1:0] phase0_r;
  logic signed [PW-1:0]         prod_x_r, prod_y_r;
  logic signed [ACC_WIDTH-1:0]  acc_x_r, acc_y_r, add_x_s, add_y_s;
  logic signed [ACC_WIDTH-1:0]  x_r, y_r, x_nxt_s, y_nxt_s, x_sh_s, y_sh_s, op_x_s, op_y_s;
  logic [15:0]                  z_r, z_nxt_s, angle_r, drop_cnt_r;
  logic [IT_W-1:0]              it_r;
  state_t                       state_r, next_s;
  logic signed [DATA_WIDTH-1:0] phase_s, diff_s, contrib_s;
  logic [DATA_WIDTH-1:0]        mag_s;
  logic                         accept_s, misalign_s, latch_s, load_s, drop_s, clear_s;

  assign {phase_s, mag_s} = s_bus.s_data_in;
  assign accept_s   = s_bus.s_valid_in && ready_r;
  assign misalign_s = accept_s && s_bus.s_last_in && (mic_idx_r != LAST_IDX);
  assign diff_s     = phase_s - phase0_r;

`ifdef LOCALIZER_MAG_WEIGHT_EN
  localparam int WW = 2 * DATA_WIDTH + 1;
  logic [DATA_WIDTH-1:0] mag0_r;
  logic signed [WW-1:0]  weighted_s;
  assign weighted_s = WW'(diff_s) * WW'($signed({1'b0, mag0_r}));
  assign contrib_s  = gate_r ? DATA_WIDTH'(weighted_s >>> DATA_WIDTH) : '0;

  // Central-mic magnitude kept for weighting the ring differences
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mag0_r <= '0;
    end else if (accept_s && (mic_idx_r == '0)) begin
      mag0_r <= mag_s;
    end
  end
`else
  assign contrib_s = gate_r ? diff_s : '0;
`endif

  // Stage 1: mic index, central-mic capture and projected products
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ready_r     <= 1'b0;
      mic_idx_r   <= '0;
      phase0_r    <= '0;
      gate_r      <= 1'b0;
      prod_x_r    <= '0;
      prod_y_r    <= '0;
      s1_valid_r  <= 1'b0;
      s1_last_r   <= 1'b0;
      s1_abort_r  <= 1'b0;
      align_err_r <= 1'b0;
    end else begin
      ready_r     <= 1'b1;
      s1_valid_r  <= 1'b0;
      s1_last_r   <= 1'b0;
      s1_abort_r  <= misalign_s;
      align_err_r <= misalign_s;
      if (accept_s) begin
        mic_idx_r <= (misalign_s || (mic_idx_r == LAST_IDX)) ? '0 : mic_idx_r + IDX_W'(1);
        if (mic_idx_r == '0) begin
          phase0_r <= phase_s;
          gate_r   <= (mag_s >= threshold_in);
        end else if (!misalign_s) begin
          s1_valid_r <= 1'b1;
          s1_last_r  <= s_bus.s_last_in;
          prod_x_r   <= PW'(contrib_s) * PW'(cos_s[mic_idx_r]);
          prod_y_r   <= PW'(contrib_s) * PW'(sin_s[mic_idx_r]);
        end
      end
    end
  end

  always_comb begin
    add_x_s = '0;
    add_y_s = '0;
    if (s1_valid_r) begin
      add_x_s = ACC_WIDTH'(prod_x_r);
      add_y_s = ACC_WIDTH'(prod_y_r);
    end else begin
      add_x_s = '0;
      add_y_s = '0;
    end
  end

  // A latch or an abort restarts the sums, but a product already in flight still lands
  assign clear_s = s2_last_r || s1_abort_r;

  // Stage 2: wrapping accumulators
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      acc_x_r   <= '0;
      acc_y_r   <= '0;
      s2_last_r <= 1'b0;
    end else begin
      s2_last_r <= s1_last_r;
      acc_x_r   <= (clear_s ? '0 : acc_x_r) + add_x_s;
      acc_y_r   <= (clear_s ? '0 : acc_y_r) + add_y_s;
    end
  end

  assign latch_s = s2_last_r;
  assign load_s  = latch_s && ((state_r == IDLE) || (state_r == DONE));
  assign drop_s  = latch_s && ((state_r == PRE) || (state_r == ITER));
  assign op_x_s  = acc_x_r >>> 2'd2;
  assign op_y_s  = acc_y_r >>> 2'd2;
  assign x_sh_s  = x_r >>> it_r;
  assign y_sh_s  = y_r >>> it_r;

  // CORDIC next-state and datapath
  always_comb begin
    next_s  = state_r;
    x_nxt_s = x_r;
    y_nxt_s = y_r;
    z_nxt_s = z_r;
    case (state_r)
      IDLE: begin
        if (latch_s) next_s = PRE;
        else         next_s = IDLE;
      end
      PRE: begin
        next_s = ITER;
        if (x_r[ACC_WIDTH-1]) begin
          x_nxt_s = -x_r;
          y_nxt_s = -y_r;
          z_nxt_s = 16'h8000;
        end else begin
          z_nxt_s = 16'h0000;
        end
      end
      ITER: begin
        if (!y_r[ACC_WIDTH-1]) begin
          x_nxt_s = x_r + y_sh_s;
          y_nxt_s = y_r - x_sh_s;
          z_nxt_s = z_r + atan_lut(it_r);
        end else begin
          x_nxt_s = x_r - y_sh_s;
          y_nxt_s = y_r + x_sh_s;
          z_nxt_s = z_r - atan_lut(it_r);
        end
        if (it_r == LAST_IT) next_s = DONE;
        else                 next_s = ITER;
      end
      DONE: begin
        if (latch_s) next_s = PRE;
        else         next_s = IDLE;
      end
      default: next_s = IDLE;
    endcase
  end

  // CORDIC state, operands and result registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r       <= IDLE;
      x_r           <= '0;
      y_r           <= '0;
      z_r           <= '0;
      it_r          <= '0;
      zero_r        <= 1'b0;
      angle_r       <= '0;
      angle_valid_r <= 1'b0;
      drop_cnt_r    <= '0;
    end else begin
      state_r       <= next_s;
      z_r           <= z_nxt_s;
      it_r          <= (state_r == ITER) ? it_r + IT_W'(1) : '0;
      angle_valid_r <= (state_r == ITER) && (it_r == LAST_IT);
      if (load_s) begin
        x_r    <= op_x_s;
        y_r    <= op_y_s;
        zero_r <= (op_x_s == '0) && (op_y_s == '0);
      end else begin
        x_r <= x_nxt_s;
        y_r <= y_nxt_s;
      end
      // A null vector has no direction; report 0 rather than the CORDIC's arbitrary residue
      if ((state_r == ITER) && (it_r == LAST_IT)) begin
        angle_r <= zero_r ? 16'h0000 : z_nxt_s;
      end
      if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

  assign s_bus.s_ready_out    = ready_r;
  assign angle_out            = angle_r;
  assign angle_valid_out      = angle_valid_r;
  assign align_err_out        = align_err_r;
  assign frame_drop_count_out = drop_cnt_r;
endmodule
